// File: rtl/layer1_max_pool.sv
// 2x2 stride-2 signed max pooling over a raster feature-map stream.
// A half-width line buffer carries even-row pair maxima into the odd row.
module layer1_max_pool #(
  parameter int FM_WIDTH  = 4,
  parameter int FM_HEIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pre_vsync,
  input  logic        pre_href,
  input  logic [15:0] pre_data,
  output logic        post_vsync,
  output logic        post_href,
  output logic [15:0] post_data,
  output logic        frame_done,
  output logic        line_err
);

  localparam int CW    = (FM_WIDTH  > 2) ? $clog2(FM_WIDTH)  : 1;
  localparam int RW    = (FM_HEIGHT > 2) ? $clog2(FM_HEIGHT) : 1;
  localparam int AW    = (CW > 1) ? CW - 1 : 1;
  localparam int DEPTH = FM_WIDTH / 2;
  localparam logic [CW-1:0] COL_LAST = CW'(FM_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FM_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ROW_EVEN = 2'd1,
    ROW_ODD  = 2'd2,
    DONE     = 2'd3
  } state_t;

  function automatic logic [15:0] f_smax(input logic [15:0] a, input logic [15:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  state_t          r_state;
  state_t          w_next;
  logic            r_vsync_d;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [15:0]     r_hold;
  logic [15:0]     r_lbuf [DEPTH];

  logic            w_in_row;
  logic            w_vs_rise;
  logic            w_abort;
  logic            w_accept;
  logic            w_short;
  logic            w_line_end;
  logic            w_last_row;
  logic            w_odd_pix;
  logic [AW-1:0]   w_addr;
  logic [15:0]     w_pair;
  logic [15:0]     w_pool;

  assign w_in_row   = (r_state == ROW_EVEN) || (r_state == ROW_ODD);
  assign w_vs_rise  = pre_vsync & ~r_vsync_d;
  assign w_abort    = w_in_row & ~pre_vsync;
  assign w_accept   = w_in_row & pre_vsync & pre_href;
  // A line that drops href part-way is closed out as if it had completed.
  assign w_short    = w_in_row & pre_vsync & ~pre_href & (r_col != {CW{1'b0}});
  assign w_line_end = (w_accept & (r_col == COL_LAST)) | w_short;
  assign w_last_row = (r_row == ROW_LAST);
  assign w_odd_pix  = w_accept & r_col[0];
  assign w_addr     = AW'(r_col >> 1);
  assign w_pair     = f_smax(r_hold, pre_data);
  assign w_pool     = f_smax(w_pair, r_lbuf[w_addr]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_vs_rise) w_next = ROW_EVEN;
        else           w_next = IDLE;
      end
      ROW_EVEN: begin
        if (w_abort)         w_next = IDLE;
        else if (w_line_end) w_next = ROW_ODD;
        else                 w_next = ROW_EVEN;
      end
      ROW_ODD: begin
        if (w_abort)         w_next = IDLE;
        else if (w_line_end) w_next = w_last_row ? DONE : ROW_EVEN;
        else                 w_next = ROW_ODD;
      end
      DONE: begin
        if (!pre_vsync) w_next = IDLE;
        else            w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Reset to 1 so a frame already running at reset release is skipped.
  always_ff @(posedge clk) begin
    if (rst) r_vsync_d <= 1'b1;
    else     r_vsync_d <= pre_vsync;
  end

  // Column/row position within the frame.
  always_ff @(posedge clk) begin
    if (rst || !w_in_row || w_abort) begin
      r_col <= {CW{1'b0}};
      r_row <= {RW{1'b0}};
    end else if (w_line_end) begin
      r_col <= {CW{1'b0}};
      r_row <= w_last_row ? {RW{1'b0}} : r_row + {{(RW-1){1'b0}}, 1'b1};
    end else if (w_accept) begin
      r_col <= r_col + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Even-column holding register and line buffer; both written before any read.
  always_ff @(posedge clk) begin
    if (w_accept && !r_col[0]) r_hold <= pre_data;
    if (w_odd_pix && (r_state == ROW_EVEN)) r_lbuf[w_addr] <= w_pair;
  end

  // Registered stream outputs and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      post_vsync <= 1'b0;
      post_href  <= 1'b0;
      post_data  <= 16'h0000;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      post_href  <= w_odd_pix & (r_state == ROW_ODD);
      line_err   <= w_short;
      frame_done <= (r_state == DONE) & post_vsync;
      if (w_odd_pix && (r_state == ROW_ODD)) post_data <= w_pool;
      if ((r_state == IDLE) && w_vs_rise)    post_vsync <= 1'b1;
      else if (w_abort || (r_state == DONE)) post_vsync <= 1'b0;
    end
  end

endmodule

// File: tb/tb_layer1_max_pool.sv
// Scoreboard bench for layer1_max_pool: expected pooled pixels and their
// arrival cycles are queued at drive time and matched as post_href fires.
module tb_layer1_max_pool;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pre_vsync = 1'b0;
  logic        pre_href = 1'b0;
  logic [15:0] pre_data = 16'h0000;
  logic        post_vsync;
  logic        post_href;
  logic [15:0] post_data;
  logic        frame_done;
  logic        line_err;

  layer1_max_pool #(.FM_WIDTH(4), .FM_HEIGHT(4)) dut (
    .clk(clk), .rst(rst), .pre_vsync(pre_vsync), .pre_href(pre_href),
    .pre_data(pre_data), .post_vsync(post_vsync), .post_href(post_href),
    .post_data(post_data), .frame_done(frame_done), .line_err(line_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  int le_cnt = 0;
  int last_href_cyc = 0;
  logic prev_vs = 1'b0;
  logic [15:0] exp_data[$];
  int exp_cyc[$];
  logic signed [15:0] pix [4][4];
  int lens [4] = '{4, 4, 4, 4};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic signed [15:0] smax(input logic signed [15:0] a, input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  // Output monitor: pops the scoreboard on every pooled pixel.
  always @(negedge clk) begin
    if (!rst) begin
      if (post_href) begin
        if (exp_data.size() == 0 || exp_cyc.size() == 0) begin
          check_eq("unexp_href", post_href, 1'b0);
        end else begin
          check_eq("pool_data", post_data, exp_data.pop_front());
          check_eq("href_lat", cyc, exp_cyc.pop_front());
        end
        last_href_cyc <= cyc;
      end
      if (frame_done) begin
        fd_cnt <= fd_cnt + 1;
        check_eq("fd_edge", {prev_vs, post_vsync}, 2'b10);
        check_eq("vs_fall_lat", cyc, last_href_cyc + 1);
      end
      if (line_err) le_cnt <= le_cnt + 1;
    end
    prev_vs <= post_vsync;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_vs"}, post_vsync, 1'b0);
    check_eq({tag, "_href"}, post_href, 1'b0);
    check_eq({tag, "_data"}, post_data, 16'h0000);
    check_eq({tag, "_fd"}, frame_done, 1'b0);
    check_eq({tag, "_le"}, line_err, 1'b0);
  endtask

  task automatic load_031();
    pix[0] = '{16'sd1, 16'sd5, 16'sd2, 16'sd3};
    pix[1] = '{16'sd4, 16'sd0, -16'sd1, 16'sd7};
    pix[2] = '{16'sd9, 16'sd8, 16'sd6, 16'sd6};
    pix[3] = '{-16'sd3, 16'sd10, 16'sd2, 16'sd1};
  endtask

  task automatic push_hand(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    exp_data.push_back(a); exp_data.push_back(b);
    exp_data.push_back(c); exp_data.push_back(d);
  endtask

  // Reference pooling straight from the 2x2 window definition.
  task automatic push_pool();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        exp_data.push_back(smax(smax(pix[2*r][2*c], pix[2*r][2*c+1]),
                                smax(pix[2*r+1][2*c], pix[2*r+1][2*c+1])));
  endtask

  // Drives one frame; may abort after abort_row or reset mid rst_row.
  task automatic drive_frame(input int abort_row, input int rst_row);
    @(posedge clk); #1;
    pre_vsync = 1'b1; pre_href = 1'b1; pre_data = 16'h7FFF;
    @(negedge clk);
    check_eq("vs_rise_pre", post_vsync, 1'b0);
    @(posedge clk); #1;
    pre_href = 1'b0;
    @(negedge clk);
    check_eq("vs_rise", post_vsync, 1'b1);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < lens[r]; c++) begin
        @(posedge clk); #1;
        if (r == rst_row && c == 1) begin
          pre_href = 1'b0; rst = 1'b1;
          @(posedge clk); @(negedge clk);
          check_outputs_zero("mid_rst");
          @(posedge clk); #1;
          rst = 1'b0;
          repeat (4) @(posedge clk);
          @(negedge clk);
          check_eq("rst_skip_vs", post_vsync, 1'b0);
          return;
        end
        pre_href = 1'b1;
        pre_data = pix[r][c];
        if ((r % 2 == 1) && (c % 2 == 1)) exp_cyc.push_back(cyc + 1);
      end
      @(posedge clk); #1;
      pre_href = 1'b0;
      if (r == abort_row) begin
        pre_vsync = 1'b0;
        @(negedge clk); @(negedge clk);
        check_eq("abort_vs", post_vsync, 1'b0);
        return;
      end
      if (r == 3) pre_vsync = 1'b0;
    end
  endtask

  task automatic settle(input string tag, input int fd_exp);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_drain"}, exp_data.size(), 0);
    check_eq({tag, "_fd"}, fd_cnt, fd_exp);
    check_eq({tag, "_vs_low"}, post_vsync, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    load_031();
    push_hand(16'd5, 16'd7, 16'd10, 16'd6);
    drive_frame(-1, -1);
    settle("basic", 1);

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pix[r][c] = 16'(-100 + r * 4 + c);
    push_hand(-16'sd95, -16'sd93, -16'sd87, -16'sd85);
    drive_frame(-1, -1);
    settle("neg", 2);

    load_031();
    exp_data.push_back(16'd5); exp_data.push_back(16'd7);
    drive_frame(1, -1);
    settle("abort", 2);
    push_hand(16'd5, 16'd7, 16'd10, 16'd6);
    drive_frame(-1, -1);
    settle("post_abort", 3);

    lens[2] = 2;
    push_hand(16'd5, 16'd7, 16'd10, 16'd3);
    drive_frame(-1, -1);
    lens[2] = 4;
    settle("short", 4);
    check_eq("line_err_cnt", le_cnt, 1);

    drive_frame(-1, 1);
    check_eq("rst_drain", exp_data.size(), 0);
    @(posedge clk); #1;
    pre_vsync = 1'b0;
    push_hand(16'd5, 16'd7, 16'd10, 16'd6);
    drive_frame(-1, -1);
    settle("after_rst", 5);

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pix[r][c] = 16'($urandom);
    push_pool();
    drive_frame(-1, -1);
    load_031();
    push_hand(16'd5, 16'd7, 16'd10, 16'd6);
    drive_frame(-1, -1);
    settle("b2b", 7);
    check_eq("line_err_final", le_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer1_max_pool.md
LAYER1_MAX_POOL -- requirements
Module: layer1_max_pool

Interface
REQ-001 SHALL have parameter FM_WIDTH, default 4, input feature-map width in pixels; even, >=2.
REQ-002 SHALL have parameter FM_HEIGHT, default 4, input feature-map height in lines; even, >=2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pre_vsync  input  1  frame-active from the feature-map read stage.
REQ-006 SHALL have port pre_href  input  1  pixel valid; high for FM_WIDTH consecutive cycles per line.
REQ-007 SHALL have port pre_data  input  16  pixel, signed two's complement.
REQ-008 SHALL have port post_vsync  output  1  pooled frame active.
REQ-009 SHALL have port post_href  output  1  one-cycle pooled-pixel valid.
REQ-010 SHALL have port post_data  output  16  pooled pixel, signed.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at pooled-frame completion.
REQ-012 SHALL have port line_err  output  1  one-cycle pulse when a line ends short of FM_WIDTH pixels.

Function
REQ-013 SHALL compute 2x2 max pooling, stride 2: output (r,c) = signed max of inputs (2r,2c),(2r,2c+1),(2r+1,2c),(2r+1,2c+1); FM_WIDTH/2 x FM_HEIGHT/2 outputs per frame, raster order.
REQ-014 SHALL keep col_cnt (0..FM_WIDTH-1) and row_cnt (0..FM_HEIGHT-1); col_cnt increments per accepted pixel; at FM_WIDTH-1 wraps to 0 and row_cnt increments.
REQ-015 SHALL hold the even-column pixel in a register and form pair_max = max(hold, pixel) on each odd-column pixel.
REQ-016 SHALL use a line buffer of FM_WIDTH/2 x 16 bits, address col_cnt>>1: even rows write pair_max, odd rows read it.
REQ-017 SHALL implement states IDLE, ROW_EVEN, ROW_ODD, DONE.
REQ-018 IDLE -> ROW_EVEN on pre_vsync rising (sampled high, previous sample low); pre_href ignored in IDLE, including the rising-edge cycle.
REQ-019 ROW_EVEN -> ROW_ODD when the pixel at col FM_WIDTH-1 is accepted.
REQ-020 ROW_ODD -> ROW_EVEN at col FM_WIDTH-1 when row_cnt < FM_HEIGHT-1; -> DONE when row_cnt == FM_HEIGHT-1.
REQ-021 DONE -> IDLE when pre_vsync is low; pre_href in DONE ignored.
REQ-022 In ROW_ODD, on each odd-column pixel: post_href=1 and post_data=max(pair_max, buffer entry) on the next cycle (1-cycle latency, registered); post_href=0 all other cycles.
REQ-023 post_vsync SHALL rise the cycle after the pre_vsync rising edge is sampled and fall the cycle after the final post_href.
REQ-024 frame_done SHALL pulse for the single cycle in which post_vsync first reads low after a completed frame.
REQ-025 pre_vsync falling in ROW_EVEN/ROW_ODD SHALL abort: next cycle state IDLE, post_vsync=0, counters cleared, no frame_done, no further post_href.
REQ-026 pre_href falling with 0 < col_cnt (line not complete) SHALL pulse line_err next cycle, clear col_cnt, advance row_cnt and row state as if the line ended; no output is produced for the missing pair.
REQ-027 Comparisons SHALL be signed 16-bit; equal operands yield that value; no width growth or saturation.

Reset
REQ-028 On rst: state IDLE, counters 0, post_vsync=0, post_href=0, post_data=0, frame_done=0, line_err=0.
REQ-029 Previous-pre_vsync register SHALL reset to 1 so a frame already in progress at reset release is skipped; the next rising edge starts a frame.
REQ-030 Line buffer and hold register SHALL NOT require reset (always written before read).

Verification
REQ-031 4x4 frame, rows [1,5,2,3],[4,0,-1,7],[9,8,6,6],[-3,10,2,1] -> post_data 5,7,10,6, each post_href one cycle after the col-1/col-3 pixel of rows 1 and 3.
REQ-032 All-negative 4x4 frame (values -100..-85) -> outputs -95,-93,-87,-85; checks signed compare.
REQ-033 Same frame, pre_vsync low after row 1 -> two outputs, post_vsync low next cycle, frame_done never pulses; next full frame correct.
REQ-034 Row 2 href held only 2 cycles -> line_err one pulse; frame continues, row-3 outputs compare against stale/partial buffer, no hang.
REQ-035 rst asserted mid-row-1 while pre_vsync high -> all outputs 0; no output until pre_vsync toggles low->high; that frame pools correctly.
REQ-036 Two back-to-back frames, one idle cycle between -> 8 outputs, two frame_done pulses, post_vsync low between frames.
